// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB pipeline stage.
//   DATA_W  : datapath and memory byte width
//   REG_W   : register-file address width
//   state_e : load sequencer states
package mem_wb_stage_pkg;

    localparam int DATA_W = 8;
    localparam int REG_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// Byte-wide data memory for the MEM stage: combinational read, synchronous write.
// Contents are deliberately not reset.
//   clk     : rising-edge clock
//   we_i    : write enable (already qualified by the caller)
//   addr_i  : byte address, already reduced modulo DEPTH
//   wdata_i : write byte
//   rdata_o : read byte at addr_i (same-cycle)
module data_mem
    import mem_wb_stage_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Synchronous byte write.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with multi-cycle loads plus the MEM/WB pipeline register.
//   clk, reset           : clock, synchronous active-high reset
//   result_out_alu       : ALU result / memory address from EX/MEM
//   writedata_out        : store data from EX/MEM
//   rd                   : destination register from EX/MEM
//   Memread..Regwrite    : control bits from EX/MEM
//   stall                : hold request to EX/MEM (combinational)
//   readdata_wb, alu_wb  : registered load data and ALU result
//   rd_wb, Memtoreg_wb,
//   Regwrite_wb          : registered control
//   wb_data              : write-back value, also the forwarding source
//   err                  : sticky flag for Memread and Memwrite together
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int LOAD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] result_out_alu,
    input  logic [DATA_W-1:0] writedata_out,
    input  logic [REG_W-1:0]  rd,
    input  logic              Memread,
    input  logic              Memtoreg,
    input  logic              Memwrite,
    input  logic              Regwrite,
    output logic              stall,
    output logic [DATA_W-1:0] readdata_wb,
    output logic [DATA_W-1:0] alu_wb,
    output logic [REG_W-1:0]  rd_wb,
    output logic              Memtoreg_wb,
    output logic              Regwrite_wb,
    output logic [DATA_W-1:0] wb_data,
    output logic              err
);

    localparam int                CNT_W    = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam int                ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);
    localparam logic [31:0]       DEPTH_U  = 32'(DEPTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  readdata_q, readdata_d;
    logic [DATA_W-1:0]  alu_q, alu_d;
    logic [REG_W-1:0]   rd_q, rd_d;
    logic               mtr_q, mtr_d;
    logic               rw_q, rw_d;

    logic               stall_s;
    logic               mem_we_s;
    logic [ADDR_W-1:0]  mem_addr_s;
    logic [DATA_W-1:0]  mem_rdata_s;

    // Address wraps modulo DEPTH; an illegal load+store is treated as a load,
    // so the write is dropped whenever Memread is set.
    assign mem_addr_s = ADDR_W'(32'(result_out_alu) % DEPTH_U);
    assign mem_we_s   = Memwrite & ~Memread & ~reset;

    data_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk     (clk),
        .we_i    (mem_we_s),
        .addr_i  (mem_addr_s),
        .wdata_i (writedata_out),
        .rdata_o (mem_rdata_s)
    );

    // Load sequencer next state and stall. The IDLE cycle of a load counts
    // as the first stall cycle, so WAIT starts with LOAD_LAT-2 remaining.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_s = 1'b0;
        if (reset) begin
            state_d = IDLE;
            cnt_d   = '0;
            stall_s = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Memread && (LOAD_LAT > 1)) begin
                        stall_s = 1'b1;
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        stall_s = 1'b1;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // MEM/WB next value: full capture when not stalling, bubble with held data otherwise.
    always_comb begin
        err_d = err_q | (Memread & Memwrite);
        if (stall_s) begin
            readdata_d = readdata_q;
            alu_d      = alu_q;
            rd_d       = '0;
            mtr_d      = 1'b0;
            rw_d       = 1'b0;
        end else begin
            readdata_d = mem_rdata_s;
            alu_d      = result_out_alu;
            rd_d       = rd;
            mtr_d      = Memtoreg;
            rw_d       = Regwrite;
        end
    end

    // State, counter, error flag and MEM/WB register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            readdata_q <= '0;
            alu_q      <= '0;
            rd_q       <= '0;
            mtr_q      <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            readdata_q <= readdata_d;
            alu_q      <= alu_d;
            rd_q       <= rd_d;
            mtr_q      <= mtr_d;
            rw_q       <= rw_d;
        end
    end

    assign stall       = stall_s;
    assign readdata_wb = readdata_q;
    assign alu_wb      = alu_q;
    assign rd_wb       = rd_q;
    assign Memtoreg_wb = mtr_q;
    assign Regwrite_wb = rw_q;
    assign err         = err_q;
    assign wb_data     = mtr_q ? readdata_q : alu_q;

endmodule
